trap_ctrl: RTL and testbench

- Trap/return sequencer in front of the machine-mode CSR file, which has a single write port.
- At commit, it detects synchronous exceptions, enabled pending interrupts and mret.
- It stalls and flushes the pipeline, then writes mepc/mcause/mtval/mstatus one per cycle and updates the privilege mode.
- It issues a single PC redirect; in IDLE it arbitrates the CSR write port between the pipeline and itself.

---
 rtl/csr_pkg.sv | 30 +++
 rtl/irq_prio.sv | 29 ++
 rtl/trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - machine-mode CSR addresses, mstatus fields, interrupt codes and trap sequencer states
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] PRV_M = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_MEPC,
      ST_W_MCAUSE,
      ST_W_MTVAL,
      ST_W_MSTATUS,
      ST_M_MSTATUS,
      ST_REDIRECT
   } trap_state_t;

endpackage

// File: rtl/irq_prio.sv
// rtl/irq_prio.sv - fixed-priority encoder for pending machine interrupts (MEI > MSI > MTI)
module irq_prio
   import csr_pkg::*;
(
   input  logic [11:0] pend,
   output logic        valid,
   output logic [3:0]  code
);

   // Only the three machine-level sources participate; the other bits are reserved here.
   logic unused_pend;
   assign unused_pend = ^{pend[10:8], pend[6:4], pend[2:0]};

   always_comb begin
      valid = 1'b0;
      code  = 4'd0;
      if (pend[IRQ_MEI]) begin
         valid = 1'b1;
         code  = IRQ_MEI;
      end else if (pend[IRQ_MSI]) begin
         valid = 1'b1;
         code  = IRQ_MSI;
      end else if (pend[IRQ_MTI]) begin
         valid = 1'b1;
         code  = IRQ_MTI;
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer owning the single CSR write port during trap entry and return
module trap_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter bit VECTORED_EN = 1'b1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            exc_valid,
   input  logic [3:0]      exc_code,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret,
   input  logic [XLEN-1:0] csr_mstatus,
   input  logic [XLEN-1:0] csr_mie,
   input  logic [XLEN-1:0] csr_mip,
   input  logic [XLEN-1:0] csr_mtvec,
   input  logic [XLEN-1:0] csr_mepc,
   input  logic [1:0]      prvmode,
   input  logic            pipe_csr_we,
   input  logic [11:0]     pipe_csr_addr,
   input  logic [XLEN-1:0] pipe_csr_wd,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wd,
   output logic            prv_we,
   output logic [1:0]      prv_next,
   output logic            stall,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   trap_state_t state, state_nx;

   logic [XLEN-1:0] epc_q, mstatus_q, mtvec_q, cause_q, tval_q;
   logic [XLEN-1:1] mepc_q;
   logic [1:0]      prv_q;
   logic            is_mret_q;

   logic            irq_valid;
   logic [3:0]      irq_code;
   logic            take_int, take_exc, take_trap, take_mret;

   logic unused_bits;
   assign unused_bits = ^{csr_mie[XLEN-1:12], csr_mip[XLEN-1:12], csr_mepc[0]};

   irq_prio u_irq_prio (
      .pend  (csr_mie[11:0] & csr_mip[11:0]),
      .valid (irq_valid),
      .code  (irq_code)
   );

   assign take_int  = commit_valid && csr_mstatus[MSTATUS_MIE] && irq_valid;
   assign take_exc  = commit_valid && exc_valid;
   assign take_trap = take_int || take_exc;
   assign take_mret = commit_valid && mret && !take_trap;

   // Vectored mode only offsets interrupt traps; exceptions always land on the base.
   logic [XLEN-1:0] trap_base, trap_target;
   assign trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_target = (VECTORED_EN && mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
                      ? trap_base + {{(XLEN-6){1'b0}}, cause_q[3:0], 2'b00}
                      : trap_base;

   logic [XLEN-1:0] ms_trap, ms_mret;
   always_comb begin
      ms_trap                                = mstatus_q;
      ms_trap[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      ms_trap[MSTATUS_MIE]                   = 1'b0;
      ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = prv_q;
      ms_mret                                = mstatus_q;
      ms_mret[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
      ms_mret[MSTATUS_MPIE]                  = 1'b1;
      ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         epc_q     <= '0;
         mstatus_q <= '0;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         cause_q   <= '0;
         tval_q    <= '0;
         prv_q     <= 2'b00;
         is_mret_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && (take_trap || take_mret)) begin
            epc_q     <= commit_pc;
            mstatus_q <= csr_mstatus;
            mtvec_q   <= csr_mtvec;
            mepc_q    <= csr_mepc[XLEN-1:1];
            prv_q     <= prvmode;
            is_mret_q <= !take_trap;
            cause_q   <= take_int ? {1'b1, {(XLEN-5){1'b0}}, irq_code}
                                  : {1'b0, {(XLEN-5){1'b0}}, exc_code};
            tval_q    <= take_int ? '0 : exc_tval;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      csr_we         = 1'b0;
      csr_addr       = 12'h000;
      csr_wd         = '0;
      prv_we         = 1'b0;
      prv_next       = 2'b00;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      // Outputs are forced quiet while reset is held, including the IDLE passthrough.
      if (rst) begin
         case (state)
            ST_IDLE: begin
               if (take_trap || take_mret) begin
                  stall    = 1'b1;
                  flush    = 1'b1;
                  state_nx = take_trap ? ST_W_MEPC : ST_M_MSTATUS;
               end else begin
                  csr_we   = pipe_csr_we;
                  csr_addr = pipe_csr_addr;
                  csr_wd   = pipe_csr_wd;
               end
            end
            ST_W_MEPC: begin
               stall    = 1'b1;
               csr_we   = 1'b1;
               csr_addr = CSR_MEPC;
               csr_wd   = epc_q;
               state_nx = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
               stall    = 1'b1;
               csr_we   = 1'b1;
               csr_addr = CSR_MCAUSE;
               csr_wd   = cause_q;
               state_nx = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
               stall    = 1'b1;
               csr_we   = 1'b1;
               csr_addr = CSR_MTVAL;
               csr_wd   = tval_q;
               state_nx = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
               stall    = 1'b1;
               csr_we   = 1'b1;
               csr_addr = CSR_MSTATUS;
               csr_wd   = ms_trap;
               prv_we   = 1'b1;
               prv_next = PRV_M;
               state_nx = ST_REDIRECT;
            end
            ST_M_MSTATUS: begin
               stall    = 1'b1;
               csr_we   = 1'b1;
               csr_addr = CSR_MSTATUS;
               csr_wd   = ms_mret;
               prv_we   = 1'b1;
               prv_next = mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
               state_nx = ST_REDIRECT;
            end
            ST_REDIRECT: begin
               stall          = 1'b1;
               redirect_valid = 1'b1;
               redirect_pc    = is_mret_q ? {mepc_q, 1'b0} : trap_target;
               state_nx       = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl with a high-level trap/mret reference model
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid, exc_valid, mret, pipe_csr_we;
   logic [63:0] commit_pc, exc_tval, pipe_csr_wd;
   logic [3:0]  exc_code;
   logic [63:0] csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc;
   logic [1:0]  prvmode;
   logic [11:0] pipe_csr_addr;
   logic        csr_we, prv_we, stall, flush, redirect_valid;
   logic [11:0] csr_addr;
   logic [63:0] csr_wd, redirect_pc;
   logic [1:0]  prv_next;

   trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval), .mret(mret),
      .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mip(csr_mip),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .prvmode(prvmode),
      .pipe_csr_we(pipe_csr_we), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wd(pipe_csr_wd),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wd(csr_wd),
      .prv_we(prv_we), .prv_next(prv_next), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        we;
      logic [11:0] addr;
      logic [63:0] wd;
      logic        pwe;
      logic [1:0]  pnext;
      logic        rv;
      logic [63:0] rpc;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic we, input logic [11:0] a, input logic [63:0] d,
                       input logic pwe, input logic [1:0] pn, input logic rv, input logic [63:0] rpc);
      ev_t e;
      e.cyc = c; e.we = we; e.addr = a; e.wd = d;
      e.pwe = pwe; e.pnext = pn; e.rv = rv; e.rpc = rpc;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   ev_t mon_e;
   bit  mon_ok;
   always @(negedge clk) begin
      if (csr_we || prv_we || redirect_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d actual we=%0b addr=%h wd=%h prv_we=%0b redir=%0b pc=%h required=none",
                     cyc, csr_we, csr_addr, csr_wd, prv_we, redirect_valid, redirect_pc);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_ok = (mon_e.cyc == cyc) && (csr_we === mon_e.we) && (prv_we === mon_e.pwe) &&
                     (redirect_valid === mon_e.rv) &&
                     (!mon_e.we || (csr_addr === mon_e.addr && csr_wd === mon_e.wd)) &&
                     (!mon_e.pwe || prv_next === mon_e.pnext) &&
                     (!mon_e.rv || redirect_pc === mon_e.rpc);
            if (!mon_ok) begin
               bad++;
               $display("FAIL event actual cyc=%0d we=%0b addr=%h wd=%h pwe=%0b pn=%0d rv=%0b rpc=%h required cyc=%0d we=%0b addr=%h wd=%h pwe=%0b pn=%0d rv=%0b rpc=%h",
                        cyc, csr_we, csr_addr, csr_wd, prv_we, prv_next, redirect_valid, redirect_pc,
                        mon_e.cyc, mon_e.we, mon_e.addr, mon_e.wd, mon_e.pwe, mon_e.pnext, mon_e.rv, mon_e.rpc);
            end
         end
      end
   end

   task automatic set_idle();
      commit_valid = 0; exc_valid = 0; mret = 0; exc_code = 0;
      commit_pc = 0; exc_tval = 0; pipe_csr_we = 0; pipe_csr_addr = 0; pipe_csr_wd = 0;
   endtask

   // Inputs that must be ignored while the sequencer is busy.
   task automatic drive_junk();
      commit_valid = 1; exc_valid = 1; mret = $urandom_range(0, 1);
      exc_code = 4'($urandom_range(0, 15));
      commit_pc = {$urandom, $urandom}; exc_tval = {$urandom, $urandom};
      csr_mstatus = {$urandom, $urandom}; csr_mepc = {$urandom, $urandom};
      csr_mtvec = {$urandom, $urandom}; prvmode = 2'($urandom_range(0, 3));
      pipe_csr_we = 1; pipe_csr_addr = 12'($urandom); pipe_csr_wd = {$urandom, $urandom};
   endtask

   task automatic txn(input logic cv, input logic ex, input logic mr, input logic [3:0] code,
                      input logic [63:0] pc, input logic [63:0] tv, input logic [63:0] ms,
                      input logic [63:0] ie, input logic [63:0] ip, input logic [63:0] tvec,
                      input logic [63:0] epc, input logic [1:0] prv, input logic pwe,
                      input logic [11:0] pa, input logic [63:0] pd, input bit abort);
      int t, lat, c;
      bit is_int, is_exc, is_mret;
      logic [63:0] pend, cause, nms, tgt;
      @(posedge clk); #1;
      commit_valid = cv; exc_valid = ex; mret = mr; exc_code = code;
      commit_pc = pc; exc_tval = tv; csr_mstatus = ms; csr_mie = ie; csr_mip = ip;
      csr_mtvec = tvec; csr_mepc = epc; prvmode = prv;
      pipe_csr_we = pwe; pipe_csr_addr = pa; pipe_csr_wd = pd;
      t = cyc;

      pend    = ie & ip & 64'h888;
      is_int  = cv && ms[3] && (pend != 0);
      is_exc  = !is_int && cv && ex;
      is_mret = !is_int && !is_exc && cv && mr;
      c       = pend[11] ? 11 : pend[3] ? 3 : 7;
      lat     = 0;
      if (is_int || is_exc) begin
         if (!is_int) c = int'(code);
         cause = 64'(c);
         if (is_int) cause[63] = 1'b1;
         nms = ms & ~64'h1888;
         if (ms[3]) nms[7] = 1'b1;
         nms[12:11] = prv;
         tgt = {tvec[63:2], 2'b00};
         if (is_int && tvec[1:0] == 2'b01) tgt = tgt + 64'(4 * c);
         push(t + 1, 1, 12'h341, pc, 0, 0, 0, 0);
         if (!abort) begin
            push(t + 2, 1, 12'h342, cause, 0, 0, 0, 0);
            push(t + 3, 1, 12'h343, is_int ? 64'h0 : tv, 0, 0, 0, 0);
            push(t + 4, 1, 12'h300, nms, 1, 2'd3, 0, 0);
            push(t + 5, 0, 12'h000, 0, 0, 0, 1, tgt);
         end
         lat = 5;
      end else if (is_mret) begin
         nms = ms & ~64'h1888;
         if (ms[7]) nms[3] = 1'b1;
         nms[7] = 1'b1;
         push(t + 1, 1, 12'h300, nms, 1, ms[12:11], 0, 0);
         push(t + 2, 0, 12'h000, 0, 0, 0, 1, {epc[63:1], 1'b0});
         lat = 2;
      end else if (pwe) begin
         push(t, 1, pa, pd, 0, 0, 0, 0);
      end
      #2;
      check("accept_stall", 64'(stall), 64'(lat != 0));
      check("accept_flush", 64'(flush), 64'(lat != 0));

      if (abort) begin
         @(posedge clk); #1; set_idle();
         @(posedge clk); #1;
         rst = 0;
         pipe_csr_we = 1; pipe_csr_addr = 12'h340; pipe_csr_wd = 64'hdead_beef;
         #1;
         check("reset_ctl", 64'({csr_we, prv_we, stall, flush, redirect_valid, prv_next, csr_addr}), 64'h0);
         check("reset_data", csr_wd | redirect_pc, 64'h0);
         @(posedge clk); #1; set_idle(); rst = 1;
         @(posedge clk); #2;
         check("post_reset_stall", 64'(stall), 64'h0);
      end else begin
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            drive_junk();
            #2;
            check("busy_stall", 64'(stall), 64'h1);
            check("busy_flush", 64'(flush), 64'h0);
         end
      end
      @(posedge clk); #1; set_idle();
      repeat (2) @(posedge clk);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'h0);
      exp_q.delete();
   endtask

   initial begin
      rst = 0;
      set_idle();
      csr_mstatus = 0; csr_mie = 0; csr_mip = 0; csr_mtvec = 0; csr_mepc = 0; prvmode = 0;
      pipe_csr_we = 1; pipe_csr_addr = 12'h340; pipe_csr_wd = 64'h1234;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({csr_we, prv_we, stall, flush, redirect_valid, prv_next, csr_addr}), 64'h0);
      check("reset_wd_pc", csr_wd | redirect_pc, 64'h0);
      set_idle();
      rst = 1;

      // ecall from U
      txn(1, 1, 0, 4'd8, 64'h8000_0010, 64'h0, 64'h8, 64'h0, 64'h0, 64'h8000_1000, 64'h0, 2'd0,
          0, 12'h0, 64'h0, 0);
      // MTI, vectored
      txn(1, 0, 0, 4'd0, 64'h8000_0200, 64'h55, 64'h8, 64'h80, 64'h80, 64'h8000_1001, 64'h0, 2'd3,
          0, 12'h0, 64'h0, 0);
      // mret
      txn(1, 0, 1, 4'd0, 64'h8000_0300, 64'h0, 64'h1880, 64'h0, 64'h0, 64'h8000_1000, 64'h8000_0014, 2'd3,
          0, 12'h0, 64'h0, 0);
      // exception and MEI together
      txn(1, 1, 0, 4'd2, 64'h8000_0400, 64'h77, 64'h8, 64'h888, 64'h880, 64'h8000_1000, 64'h0, 2'd0,
          0, 12'h0, 64'h0, 0);
      // pipeline write passthrough, then dropped on accept
      txn(0, 0, 0, 4'd0, 64'h0, 64'h0, 64'h8, 64'h0, 64'h0, 64'h8000_1000, 64'h0, 2'd3,
          1, 12'h340, 64'hcafe_f00d, 0);
      txn(1, 1, 0, 4'd11, 64'h8000_0500, 64'h0, 64'h8, 64'h0, 64'h0, 64'h8000_1000, 64'h0, 2'd3,
          1, 12'h340, 64'hcafe_f00d, 0);
      // reset during W_MCAUSE
      txn(1, 1, 0, 4'd8, 64'h8000_0600, 64'h0, 64'h8, 64'h0, 64'h0, 64'h8000_1000, 64'h0, 2'd0,
          1, 12'h340, 64'h1, 1);

      for (int i = 0; i < 60; i++) begin
         logic [63:0] ms, tvec;
         ms = {$urandom, $urandom};
         tvec = {$urandom, $urandom};
         tvec[1] = 1'b0;
         txn(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
             4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, ms,
             64'($urandom_range(0, 4095)), 64'($urandom_range(0, 4095)), tvec,
             {$urandom, $urandom}, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 12'($urandom), {$urandom, $urandom}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
